ssm_rd: RTL

SSM_RD -- requirements
Module: ssm_rd

---
 rtl/ssm_rd.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ssm_rd.sv
// ssm_rd: replays up to 16 stored packets from slot RAM (128 words per slot).
// Each slot is streamed word by word with a one-cycle RAM read latency.
// Word 5 of each packet is restamped with the local TX time.
// Malformed slots are truncated or skipped and counted in rd_err_cnt.
module ssm_rd #(
    parameter PLATFORM = "Xilinx-OpenBox-S4"
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_rd,
    input  logic [4:0]   pkt_total,
    input  logic [63:0]  lcm2ssm_rd_time,
    output logic [10:0]  ssm_rd_addr,
    output logic         ssm_rd_en,
    input  logic [133:0] in_ssm_rdata,
    input  logic         out_alf,
    output logic [133:0] out_ssm_rd_data,
    output logic         out_ssm_rd_data_wr,
    output logic         out_ssm_rd_valid,
    output logic         out_ssm_rd_valid_wr,
    output logic         rd_busy,
    output logic         rd_done,
    output logic [7:0]   rd_err_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_STREAM, S_VALID, S_DONE} state_t;

    state_t       r_state;
    logic [4:0]   r_n;         // packets to replay, already clamped to 16
    logic [3:0]   r_slot;
    logic [6:0]   r_ridx;      // index of the word currently returning from RAM
    logic         r_inflight;  // a read issued last cycle returns data this cycle
    logic         r_good;
    logic [63:0]  r_ts;
    logic [10:0]  r_addr;
    logic         r_en;
    logic [133:0] r_data;
    logic         r_data_wr;
    logic         r_valid;
    logic         r_valid_wr;
    logic         r_done;
    logic [7:0]   r_err;

    // The platform tag is informational only.
    logic         w_unused_platform;
    assign w_unused_platform = ^PLATFORM;

    logic [1:0]   w_tag;
    logic         w_more;
    logic [7:0]   w_err_next;
    logic         w_bad_head;
    logic         w_mid_head;
    logic         w_tail;
    logic         w_last;
    logic         w_term;
    logic         w_issue;
    logic [133:0] w_word;

    assign w_tag      = in_ssm_rdata[133:132];
    assign w_more     = ({1'b0, r_slot} + 5'd1) < r_n;
    assign w_err_next = (r_err == 8'hFF) ? r_err : r_err + 8'd1;
    assign w_bad_head = r_inflight && (r_ridx == 7'd0) && (w_tag != 2'b01);
    assign w_mid_head = r_inflight && (r_ridx != 7'd0) && (w_tag == 2'b01);
    assign w_tail     = r_inflight && (r_ridx != 7'd0) && (w_tag == 2'b10);
    assign w_last     = r_inflight && (r_ridx == 7'd127);
    // Any of these ends the slot, so no further read may be issued for it.
    assign w_term     = w_bad_head || w_mid_head || w_tail || w_last;
    assign w_issue    = !out_alf && (r_addr[6:0] != 7'd127) && !w_term;

    // Word 5 carries the TX timestamp in its middle quadword.
    always_comb begin
        w_word = in_ssm_rdata;
        if (r_ridx == 7'd5)
            w_word[127:64] = r_ts;
    end

    // Replay FSM with registered outputs and the one-deep read pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_n        <= '0;
            r_slot     <= '0;
            r_ridx     <= '0;
            r_inflight <= 1'b0;
            r_good     <= 1'b0;
            r_ts       <= '0;
            r_addr     <= '0;
            r_en       <= 1'b0;
            r_data     <= '0;
            r_data_wr  <= 1'b0;
            r_valid    <= 1'b0;
            r_valid_wr <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= '0;
        end else begin
            r_en       <= 1'b0;
            r_data_wr  <= 1'b0;
            r_valid_wr <= 1'b0;
            r_done     <= 1'b0;
            r_inflight <= r_en;
            // The head is on the output this cycle: take its TX time.
            if (r_state == S_STREAM && r_data_wr && r_ridx == 7'd1)
                r_ts <= lcm2ssm_rd_time;
            case (r_state)
                S_IDLE: begin
                    if (start_rd) begin
                        r_n     <= (pkt_total > 5'd16) ? 5'd16 : pkt_total;
                        r_slot  <= '0;
                        r_state <= (pkt_total == 5'd0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_addr  <= {r_slot, 7'd0};
                    r_en    <= 1'b1;
                    r_ridx  <= '0;
                    r_state <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_issue) begin
                        r_addr <= r_addr + 11'd1;
                        r_en   <= 1'b1;
                    end
                    if (w_bad_head) begin
                        // Skip the whole slot without a valid strobe.
                        r_err <= w_err_next;
                        if (w_more) begin
                            r_slot  <= r_slot + 4'd1;
                            r_state <= S_FETCH;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end else if (w_mid_head) begin
                        r_err   <= w_err_next;
                        r_good  <= 1'b0;
                        r_state <= S_VALID;
                    end else if (w_tail) begin
                        r_data    <= w_word;
                        r_data_wr <= 1'b1;
                        r_good    <= 1'b1;
                        r_state   <= S_VALID;
                    end else if (w_last) begin
                        r_data    <= {2'b10, w_word[131:0]};
                        r_data_wr <= 1'b1;
                        r_err     <= w_err_next;
                        r_good    <= 1'b0;
                        r_state   <= S_VALID;
                    end else if (r_inflight) begin
                        r_data    <= w_word;
                        r_data_wr <= 1'b1;
                        r_ridx    <= r_ridx + 7'd1;
                    end
                end
                S_VALID: begin
                    r_valid_wr <= 1'b1;
                    r_valid    <= r_good;
                    if (w_more) begin
                        r_slot  <= r_slot + 4'd1;
                        r_state <= S_FETCH;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ssm_rd_addr         = r_addr;
    assign ssm_rd_en           = r_en;
    assign out_ssm_rd_data     = r_data;
    assign out_ssm_rd_data_wr  = r_data_wr;
    assign out_ssm_rd_valid    = r_valid;
    assign out_ssm_rd_valid_wr = r_valid_wr;
    assign rd_busy             = (r_state != S_IDLE);
    assign rd_done             = r_done;
    assign rd_err_cnt          = r_err;

endmodule
